shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 147 ++++++++++++++
 tb/tb_shift_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Upstream control stage for an N-bit shift_register. A word is accepted
//   over a valid/ready handshake. The sequencer then drives the register's
//   ctrl/data inputs: one parallel-load cycle, then exactly N shift cycles in
//   the requested direction, then GAP hold cycles. After that it is idle again.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   upstream word valid
//   in_ready   sequencer idle and able to accept a word (low during reset)
//   in_data    word to load (N bits)
//   in_dir     0 = shift right (ctrl=1), 1 = shift left (ctrl=2)
//   pause      freezes the shift phase while high (one-cycle latency to ctrl)
//   ctrl       to shift_register.ctrl: 0 hold, 1 right, 2 left, 3 load
//   data       to shift_register.data (load word during LOAD, else 0)
//   busy       high whenever the sequencer is not idle
//   shift_cnt  shifts issued for the current word (holds N until next load)
//   done       one-cycle pulse on the final cycle of a word's sequence
module shift_sequencer #(
    parameter int N   = 8,
    parameter int GAP = 2,
    parameter int CW  = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_dir,
    input  logic          pause,
    output logic [1:0]    ctrl,
    output logic [N-1:0]  data,
    output logic          busy,
    output logic [CW-1:0] shift_cnt,
    output logic          done
);
    // The gap counter holds the number of GAP cycles still to come after the current one.
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] C_HOLD  = 2'd0;
    localparam logic [1:0] C_RIGHT = 2'd1;
    localparam logic [1:0] C_LEFT  = 2'd2;
    localparam logic [1:0] C_LOAD  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t          state_q;
    logic            dir_q;
    logic [1:0]      ctrl_q;
    logic [N-1:0]    data_q;
    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic            done_q;
    logic [GW-1:0]   gap_q;

    logic            fire;
    logic [1:0]      dir_ctrl;

    assign in_ready = (state_q == S_IDLE) && !reset;
    assign fire     = in_valid && in_ready;
    assign dir_ctrl = dir_q ? C_LEFT : C_RIGHT;

    assign ctrl      = ctrl_q;
    assign data      = data_q;
    assign busy      = busy_q;
    assign shift_cnt = cnt_q;
    assign done      = done_q;

    // Every output is registered, so each branch below sets the values for the
    // cycle that follows the edge. In SHIFT, a non-zero ctrl_q means the current
    // cycle issues a shift. A zero ctrl_q means the current cycle is paused.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            ctrl_q  <= C_HOLD;
            data_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ctrl_q <= C_HOLD;
                    data_q <= '0;
                    if (fire) begin
                        state_q <= S_LOAD;
                        dir_q   <= in_dir;
                        ctrl_q  <= C_LOAD;
                        data_q  <= in_data;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_LOAD: begin
                    // LOAD always lasts one cycle. pause only decides whether
                    // the first SHIFT cycle issues a shift.
                    state_q <= S_SHIFT;
                    data_q  <= '0;
                    ctrl_q  <= pause ? C_HOLD : dir_ctrl;
                    done_q  <= (GAP == 0) && (N == 1) && !pause;
                end
                S_SHIFT: begin
                    if (ctrl_q != C_HOLD) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) begin
                            ctrl_q <= C_HOLD;
                            if (GAP == 0) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_GAP;
                                gap_q   <= GW'(GAP - 1);
                                done_q  <= (GAP == 1);
                            end
                        end else begin
                            ctrl_q <= pause ? C_HOLD : dir_ctrl;
                            // With no gap, done marks the cycle of the final shift.
                            done_q <= (GAP == 0) && !pause && (cnt_q == CW'(N - 2));
                        end
                    end else begin
                        ctrl_q <= pause ? C_HOLD : dir_ctrl;
                        done_q <= (GAP == 0) && !pause && (cnt_q == CW'(N - 1));
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q  <= gap_q - GW'(1);
                        done_q <= (gap_q == GW'(1));
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ctrl_q  <= C_HOLD;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
    localparam int N   = 8;
    localparam int GAP = 2;
    localparam int CW  = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_dir;
    logic          pause;
    logic [1:0]    ctrl;
    logic [N-1:0]  data;
    logic          busy;
    logic [CW-1:0] shift_cnt;
    logic          done;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [1:0]   ctrl;
        logic [N-1:0] data;
        logic         done;
        int           cnt;
    } exp_t;

    shift_sequencer #(.N(N), .GAP(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .pause     (pause),
        .ctrl      (ctrl),
        .data      (data),
        .busy      (busy),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) passes = passes + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // One word from handshake to the return to idle. On entry the bench is at
    // the negedge of an idle cycle. On exit it is at the negedge of the next
    // idle cycle. pm[t] is the pause level driven during the cycle before
    // shift-phase cycle t, so pm[0] is driven during the load cycle.
    task automatic do_word(input logic [N-1:0] w, input logic dir, input logic [63:0] pm,
                           input logic keep, input logic [N-1:0] nw, input logic ndir);
        exp_t         e[$];
        int           issued;
        int           t;
        logic [N-1:0] sr;
        logic [1:0]   dc;

        chk("idle_ctrl", ctrl, 0);
        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        in_valid = 1'b1;
        in_data  = w;
        in_dir   = dir;
        pause    = 1'($urandom_range(0, 1));

        // Expected stream: one load, then N shifts interleaved with paused
        // hold cycles, then GAP hold cycles, with done on the last cycle.
        dc = dir ? 2'd2 : 2'd1;
        e.push_back('{2'd3, w, 1'b0, 0});
        issued = 0;
        t = 0;
        while (issued < N) begin
            if (t < 64 && pm[t]) begin
                e.push_back('{2'd0, '0, 1'b0, issued});
            end else begin
                e.push_back('{dc, '0, (GAP == 0) && (issued == N - 1), issued});
                issued++;
            end
            t++;
        end
        for (int g = 0; g < GAP; g++)
            e.push_back('{2'd0, '0, g == GAP - 1, N});

        sr = '0;
        foreach (e[i]) begin
            @(negedge clk);
            chk("seq_ctrl", ctrl, e[i].ctrl);
            chk("seq_data", data, e[i].data);
            chk("seq_done", done, e[i].done);
            chk("seq_cnt", shift_cnt, e[i].cnt);
            chk("seq_busy", busy, 1);
            chk("seq_ready", in_ready, 0);
            case (ctrl)
                2'd3: sr = data;
                2'd1: sr = sr >> 1;
                2'd2: sr = sr << 1;
                default: sr = sr;
            endcase
            if (i == 0) begin
                if (keep) begin
                    in_data = nw;
                    in_dir  = ndir;
                end else begin
                    in_valid = 1'b0;
                    in_data  = N'($urandom);
                    in_dir   = 1'($urandom);
                end
            end
            pause = (i < 64) ? pm[i] : 1'b0;
        end
        @(negedge clk);
        pause = 1'b0;
        chk("shreg_after", sr, 0);
        chk("cnt_hold", shift_cnt, N);
    endtask

    logic [N-1:0] words [100];
    logic         dirs  [100];

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        pause    = 1'b0;

        // Reset for 20 cycles, with in_valid raised near the end: reset wins.
        repeat (18) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_ctrl", ctrl, 0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (2) @(negedge clk);
        chk("rst_ready_valid", in_ready, 0);
        chk("rst_busy", busy, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ctrl", ctrl, 0);
        chk("post_rst_data", data, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_done", done, 0);
        chk("post_rst_cnt", shift_cnt, 0);

        // Directed words: right shift, left shift, pause after the 4th shift.
        do_word(8'h55, 1'b0, 64'h0, 1'b0, '0, 1'b0);
        do_word(8'h0F, 1'b1, 64'h0, 1'b0, '0, 1'b0);
        do_word(8'hA5, 1'b0, 64'h70, 1'b0, '0, 1'b0);

        // Random words with random pause patterns.
        for (int k = 0; k < 10; k++)
            do_word(N'($urandom), 1'($urandom),
                    {$urandom, $urandom} & {$urandom, $urandom} & 64'h7FFF_FFFF,
                    1'b0, '0, 1'b0);

        // Back-to-back: in_valid held high over 100 random words.
        for (int k = 0; k < 100; k++) begin
            words[k] = N'($urandom);
            dirs[k]  = 1'($urandom);
        end
        for (int k = 0; k < 100; k++) begin
            if (k < 99)
                do_word(words[k], dirs[k], 64'h0, 1'b1, words[k+1], dirs[k+1]);
            else
                do_word(words[k], dirs[k], 64'h0, 1'b0, '0, 1'b0);
        end

        // Reset in mid-shift (shift_cnt=5), with in_valid also high.
        in_valid = 1'b1;
        in_data  = 8'hC3;
        in_dir   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_cnt", shift_cnt, 5);
        chk("mid_ctrl", ctrl, 1);
        reset    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("abort_ctrl", ctrl, 0);
        chk("abort_cnt", shift_cnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", in_ready, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("after_abort_ctrl", ctrl, 0);
        chk("after_abort_done", done, 0);
        chk("after_abort_ready", in_ready, 1);
        do_word(8'h3C, 1'b1, 64'h0, 1'b0, '0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
